// File: rtl/ctrl_pkg.sv
`default_nettype none
// Shared state, ALU, condition and mux-select encodings for the multicycle control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_t;

  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ = 4'h0;
  localparam cond_t COND_NE = 4'h1;
  localparam cond_t COND_CS = 4'h2;
  localparam cond_t COND_CC = 4'h3;
  localparam cond_t COND_MI = 4'h4;
  localparam cond_t COND_PL = 4'h5;
  localparam cond_t COND_VS = 4'h6;
  localparam cond_t COND_VC = 4'h7;
  localparam cond_t COND_HI = 4'h8;
  localparam cond_t COND_LS = 4'h9;
  localparam cond_t COND_GE = 4'ha;
  localparam cond_t COND_LT = 4'hb;
  localparam cond_t COND_GT = 4'hc;
  localparam cond_t COND_LE = 4'hd;
  localparam cond_t COND_AL = 4'he;
  localparam cond_t COND_NV = 4'hf;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// Combinational ARM condition-code evaluator against the architectural NZCV flags.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       condex_o
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = flags_i[FLAG_N];
  assign w_z  = flags_i[FLAG_Z];
  assign w_c  = flags_i[FLAG_C];
  assign w_v  = flags_i[FLAG_V];
  assign w_ge = w_n ^ w_v;

  always_comb begin
    condex_o = 1'b0;
    case (cond_i)
      COND_EQ: condex_o = w_z;
      COND_NE: condex_o = ~w_z;
      COND_CS: condex_o = w_c;
      COND_CC: condex_o = ~w_c;
      COND_MI: condex_o = w_n;
      COND_PL: condex_o = ~w_n;
      COND_VS: condex_o = w_v;
      COND_VC: condex_o = ~w_v;
      COND_HI: condex_o = ~w_z & w_c;
      COND_LS: condex_o = w_z | ~w_c;
      COND_GE: condex_o = ~w_ge;
      COND_LT: condex_o = w_ge;
      COND_GT: condex_o = ~w_z & ~w_ge;
      COND_LE: condex_o = w_z | w_ge;
      COND_AL: condex_o = 1'b1;
      COND_NV: condex_o = 1'b0;
      default: condex_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// Moore-FSM control unit for the multicycle ARM-subset core; owns NZCV and
// gates every architectural write with the condition latched in DECODE.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         cond,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic [3:0]         rd,
  input  logic [3:0]         alu_flags,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic [1:0]         reg_src,
  output logic               reg_write,
  output logic [3:0]         flags_q,
  output logic [STATE_W-1:0] state_o
);

  state_t    state_q, state_d;
  logic      condex_q, condex_d;
  logic [3:0] flags_d;

  logic      w_condex;
  logic      w_cmd_ok;
  logic      w_is_exec;
  alu_ctrl_t w_alu_op;
  logic      w_pc_write, w_mem_write, w_ir_write, w_reg_write;

  cond_eval u_cond_eval (
    .cond_i   (cond),
    .flags_i  (flags_q),
    .condex_o (w_condex)
  );

  always_comb begin
    w_cmd_ok = 1'b1;
    w_alu_op = ALU_ADD;
    case (funct[4:1])
      CMD_ADD: w_alu_op = ALU_ADD;
      CMD_SUB: w_alu_op = ALU_SUB;
      CMD_AND: w_alu_op = ALU_AND;
      CMD_ORR: w_alu_op = ALU_ORR;
      default: w_cmd_ok = 1'b0;
    endcase
  end

  assign w_is_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

  // Condition is frozen on leaving DECODE so flag updates in execute cannot
  // retroactively change gating of the instruction that produced them.
  always_comb begin
    condex_d = (state_q == S_DECODE) ? w_condex : condex_q;
    flags_d  = flags_q;
    if (w_is_exec && funct[0] && condex_q && w_cmd_ok) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      if ((w_alu_op == ALU_ADD) || (w_alu_op == ALU_SUB)) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_MEMADR: alu_src_b = SRCB_EXTIMM;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWR: begin
        adr_src     = 1'b1;
        w_mem_write = condex_q;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        w_reg_write = condex_q;
      end
      S_EXECR: begin
        alu_src_b   = SRCB_RD2;
        alu_control = w_alu_op;
      end
      S_EXECI: begin
        alu_src_b   = SRCB_EXTIMM;
        alu_control = w_alu_op;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        w_reg_write = condex_q & w_cmd_ok;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_EXTIMM;
        result_src = RES_ALURESULT;
        w_pc_write = condex_q;
      end
      default: ;
    endcase
    // A writeback to R15 is a jump, so it must also load the PC.
    if (((state_q == S_MEMWB) || (state_q == S_ALUWB)) && (rd == 4'hf) && w_reg_write)
      w_pc_write = 1'b1;
  end

  assign pc_write  = w_pc_write  & reset_n;
  assign ir_write  = w_ir_write  & reset_n;
  assign mem_write = w_mem_write & reset_n;
  assign reg_write = w_reg_write & reset_n;

  assign imm_src = op;
  assign reg_src = {op == OP_MEM, op == OP_BR};
  assign state_o = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Self-checking bench for multicycle_ctrl: instruction-level model plus directed programs.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       reg_write;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] cond = 4'h0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'h0;
  logic [3:0] alu_flags = 4'h0;

  logic       pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0] flags_q;
  logic [3:0] state_o;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cond        (cond),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .reg_write   (reg_write),
    .flags_q     (flags_q),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  outs_t dut_o;
  assign dut_o = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_control, imm_src, reg_src, reg_write};

  int          checks = 0;
  int          errors = 0;
  logic        exp_en = 1'b0;
  int          exp_state = 0;
  outs_t       exp_o = '0;
  logic [3:0]  mflags = 4'h0;

  int          seen[$];
  logic        r_saw_rw, r_saw_mw, r_br_pc, r_wb_pc, r_first_irpc;
  int          r_lat;
  logic [31:0] r_trace;

  // ARM condition table: cond[3:1] picks the predicate, cond[0] inverts it.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] & ~f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic int alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic outs_t model_outs(input int s, input logic [1:0] op_, input logic [5:0] f,
                                       input logic [3:0] r, input logic ce, input logic in_rst);
    outs_t o;
    int    code;
    o = '0;
    code = alu_code(f[4:1]);
    o.imm_src = op_;
    o.reg_src = {op_ == 2'b01, op_ == 2'b10};
    case (s)
      0: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
               o.ir_write = 1'b1; o.pc_write = 1'b1; end
      1: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10; end
      2: o.alu_src_b = 2'b01;
      3: o.adr_src = 1'b1;
      4: begin o.result_src = 2'b01; o.reg_write = ce; end
      5: begin o.adr_src = 1'b1; o.mem_write = ce; end
      6: begin o.alu_src_b = 2'b00; o.alu_control = (code >= 0) ? 2'(code) : 2'b00; end
      7: begin o.alu_src_b = 2'b01; o.alu_control = (code >= 0) ? 2'(code) : 2'b00; end
      8: begin o.result_src = 2'b00; o.reg_write = ce & (code >= 0); end
      9: begin o.alu_src_b = 2'b01; o.result_src = 2'b10; o.pc_write = ce; end
      default: ;
    endcase
    if ((s == 4 || s == 8) && r == 4'hf && o.reg_write) o.pc_write = 1'b1;
    if (in_rst) begin
      o.pc_write = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0; o.reg_write = 1'b0;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      checks++;
      if (state_o !== 4'(exp_state)) begin
        errors++;
        $display("FAIL state actual %0d required %0d at %0t", state_o, exp_state, $time);
      end
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL outputs actual %h required %h in state %0d at %0t", dut_o, exp_o, exp_state, $time);
      end
      checks++;
      if (flags_q !== mflags) begin
        errors++;
        $display("FAIL flags actual %b required %b at %0t", flags_q, mflags, $time);
      end
    end
  end

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o_, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af, input int abort_step);
    int   path[$];
    logic ce;
    int   code;
    cond = c; op = o_; funct = f; rd = r; alu_flags = af;
    path = {0, 1};
    case (o_)
      2'b00: begin path.push_back(f[5] ? 7 : 6); path.push_back(8); end
      2'b01: begin
        path.push_back(2);
        if (f[0]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'b10: path.push_back(9);
      default: ;
    endcase
    ce = cond_model(c, mflags);
    code = alu_code(f[4:1]);
    seen.delete();
    r_saw_rw = 1'b0; r_saw_mw = 1'b0; r_br_pc = 1'b0; r_wb_pc = 1'b0; r_first_irpc = 1'b0;
    r_lat = 0; r_trace = 32'h0;
    for (int i = 0; i < path.size(); i++) begin
      exp_state = path[i];
      exp_o = model_outs(path[i], o_, f, r, ce, 1'b0);
      if (i == abort_step) begin
        reset_n = 1'b0;
        mflags = 4'h0;
        exp_state = 0;
        exp_o = model_outs(0, o_, f, r, 1'b0, 1'b1);
        #1;
        check("rst_async_state", 32'(state_o), 32'h0);
        check("rst_async_flags", 32'(flags_q), 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        exp_o = model_outs(0, o_, f, r, 1'b0, 1'b0);
        return;
      end
      #3;
      seen.push_back(int'(state_o));
      r_saw_rw = r_saw_rw | reg_write;
      r_saw_mw = r_saw_mw | mem_write;
      if (path[i] == 9) r_br_pc = pc_write;
      if (path[i] == 4 || path[i] == 8) r_wb_pc = pc_write;
      if (i == 0) r_first_irpc = ir_write & pc_write;
      @(posedge clk); #1;
      if ((path[i] == 6 || path[i] == 7) && f[0] && ce && code >= 0) begin
        if (code <= 1) mflags = af;
        else mflags = {af[3], af[2], mflags[1:0]};
      end
    end
    exp_state = 0;
    exp_o = model_outs(0, o_, f, r, ce, 1'b0);
    r_lat = 99;
    for (int k = seen.size() - 1; k >= 1; k--) if (seen[k] == 0) r_lat = k;
    if (r_lat == 99 && state_o == 4'h0) r_lat = seen.size();
    foreach (seen[k]) r_trace = (r_trace << 4) | 32'(seen[k]);
  endtask

  initial begin
    cond = 4'he; op = 2'b00; funct = 6'b001001; rd = 4'd1; alu_flags = 4'b0110;
    #1 reset_n = 1'b0;
    exp_en = 1'b1;
    exp_state = 0;
    exp_o = model_outs(0, op, funct, rd, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    #3;
    check("rst_state", 32'(state_o), 32'h0);
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_we", 32'({pc_write, ir_write, mem_write, reg_write}), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ADDS AL, flags 0110
    run_instr(4'he, 2'b00, 6'b001001, 4'd1, 4'b0110, -1);
    check("first_fetch_ir_pc", 32'(r_first_irpc), 32'h1);
    check("adds_trace", r_trace, 32'h0168);
    check("adds_lat", 32'(r_lat), 32'd4);
    check("adds_rw", 32'(r_saw_rw), 32'h1);
    check("adds_flags", 32'(flags_q), 32'h6);

    // SUBS sets 0011, then ANDS holds C,V
    run_instr(4'he, 2'b00, 6'b000101, 4'd2, 4'b0011, -1);
    check("subs_flags", 32'(flags_q), 32'h3);
    run_instr(4'he, 2'b00, 6'b000001, 4'd3, 4'b1000, -1);
    check("ands_flags", 32'(flags_q), 32'hb);

    // BEQ taken (Z=1) and not taken (Z=0)
    run_instr(4'he, 2'b00, 6'b001001, 4'd1, 4'b0100, -1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    check("beq_taken_pc", 32'(r_br_pc), 32'h1);
    check("beq_taken_lat", 32'(r_lat), 32'd3);
    check("beq_trace", r_trace, 32'h019);
    run_instr(4'he, 2'b00, 6'b111001, 4'd4, 4'b0000, -1);
    check("orrs_imm_flags", 32'(flags_q), 32'h0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    check("beq_nt_pc", 32'(r_br_pc), 32'h0);
    check("beq_nt_lat", 32'(r_lat), 32'd3);

    // LDR LT: true with N=1,V=0; false with N=1,V=1
    run_instr(4'he, 2'b00, 6'b001001, 4'd1, 4'b1000, -1);
    run_instr(4'hb, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);
    check("ldr_lt_lat", 32'(r_lat), 32'd5);
    check("ldr_lt_trace", r_trace, 32'h01234);
    check("ldr_lt_rw", 32'(r_saw_rw), 32'h1);
    run_instr(4'he, 2'b00, 6'b001001, 4'd1, 4'b1001, -1);
    run_instr(4'hb, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);
    check("ldr_nlt_rw", 32'(r_saw_rw), 32'h0);
    check("ldr_nlt_lat", 32'(r_lat), 32'd5);

    // STR never-condition vs always
    run_instr(4'hf, 2'b01, 6'b011000, 4'd5, 4'b0000, -1);
    check("str_nv_mw", 32'(r_saw_mw), 32'h0);
    check("str_nv_lat", 32'(r_lat), 32'd4);
    check("str_trace", r_trace, 32'h0125);
    run_instr(4'he, 2'b01, 6'b011000, 4'd5, 4'b0000, -1);
    check("str_al_mw", 32'(r_saw_mw), 32'h1);

    // ADD to R15 also writes PC; unsupported cmd writes nothing
    run_instr(4'he, 2'b00, 6'b001000, 4'hf, 4'b0110, -1);
    check("add_r15_pc", 32'(r_wb_pc), 32'h1);
    check("add_nos_flags", 32'(flags_q), 32'h9);
    run_instr(4'he, 2'b00, 6'b011111, 4'd6, 4'b0110, -1);
    check("badcmd_rw", 32'(r_saw_rw), 32'h0);
    check("badcmd_flags", 32'(flags_q), 32'h9);

    // Reset pulsed during MEMRD
    run_instr(4'he, 2'b01, 6'b011001, 4'd7, 4'b0000, 3);
    check("abort_rw", 32'(r_saw_rw), 32'h0);
    run_instr(4'he, 2'b00, 6'b001001, 4'd1, 4'b0110, -1);
    check("post_rst_lat", 32'(r_lat), 32'd4);
    check("post_rst_flags", 32'(flags_q), 32'h6);

    exp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
